// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle signed/unsigned MULT/DIV into HI/LO over a start/busy/done handshake.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU finish at once with illegal_op.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             illegal_op
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mul_next, prod_fix;
    logic [WIDTH-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   abs_a, abs_b, q_fix, r_fix;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d, ill_q, ill_d, done_q, done_d;
    logic               dbz_flag_q, dbz_flag_d, ill_flag_q, ill_flag_d;
    logic               sgn, neg_a, neg_b, dbz, ill;
    logic [WIDTH:0]     mul_sum;

    assign sgn   = ~op[0];
    assign neg_a = sgn & a[WIDTH-1];
    assign neg_b = sgn & b[WIDTH-1];
    assign abs_a = neg_a ? -a : a;
    assign abs_b = neg_b ? -b : b;

    // acc holds {partial product, remaining multiplier bits}; carry re-enters on the shift
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? m_q : {WIDTH{1'b0}}};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign q_fix    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign r_fix    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_DIV_EN
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH:0]     rem, diff;
    assign dbz  = op[1] && b == '0;
    assign ill  = 1'b0;
    // acc holds {remainder, dividend shifting out / quotient shifting in}
    assign rem      = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff     = rem - {1'b0, m_q};
    assign div_next = diff[WIDTH] ? {rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`else
    assign dbz  = 1'b0;
    assign ill  = op[1];
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;
        ill_d      = ill_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_flag_d = dbz_flag_q;
        ill_flag_d = ill_flag_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = (dbz || ill) ? FIN : RUN;
                acc_d      = dbz ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, abs_a};
                m_d        = abs_b;
                cnt_d      = '0;
                div_d      = op[1];
                neg_res_d  = neg_a ^ neg_b;
                neg_rem_d  = neg_a;
                dbz_d      = dbz;
                ill_d      = ill;
                dbz_flag_d = 1'b0;
                ill_flag_d = 1'b0;
            end
            RUN: begin
`ifdef MULDIV_DIV_EN
                acc_d = div_q ? div_next : mul_next;
`else
                acc_d = mul_next;
`endif
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
            end
            FIN: begin
                state_d    = IDLE;
                done_d     = 1'b1;
                dbz_flag_d = dbz_q;
                ill_flag_d = ill_q;
                if (!ill_q) begin
                    hi_d = dbz_q ? acc_q[2*WIDTH-1:WIDTH] : div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = dbz_q ? acc_q[WIDTH-1:0] : div_q ? q_fix : prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            ill_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_flag_q <= 1'b0;
            ill_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
            ill_q      <= ill_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_flag_q <= dbz_flag_d;
            ill_flag_q <= ill_flag_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_flag_q;
    assign illegal_op  = ill_flag_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit at WIDTH=32; divide tests need MULDIV_DIV_EN.
module tb_mul_div_unit;
    localparam int W = 32;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic        ill;
        logic [7:0]  lat;
    } exp_t;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy, done, div_by_zero, illegal_op;
    logic [W-1:0]  hi, lo;
    int            checks = 0, fails = 0;
    exp_t          sb[$];
    logic [31:0]   last_hi = '0, last_lo = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic d, input logic i, input int lt);
        mk = '{h, l, d, i, 8'(lt)};
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        exp_t r;
        r = '0;
        if (o == 2'b00) begin
            p = longint'($signed(x)) * longint'($signed(y));
            r = mk(p[63:32], p[31:0], 1'b0, 1'b0, 33);
        end else if (o == 2'b01) begin
            p = {32'b0, x} * {32'b0, y};
            r = mk(p[63:32], p[31:0], 1'b0, 1'b0, 33);
        end else begin
`ifdef MULDIV_DIV_EN
            if (y == 32'd0) r = mk(x, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
            else if (o == 2'b11) r = mk(x % y, x / y, 1'b0, 1'b0, 33);
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = mk(32'd0, 32'h8000_0000, 1'b0, 1'b0, 33);
            else r = mk(32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y)), 1'b0, 1'b0, 33);
`else
            r = mk(last_hi, last_lo, 1'b0, 1'b1, 1);
`endif
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
        start = 1'b1; op = o; a = x; b = y;
        sb.push_back(e);
        last_hi = e.hi; last_lo = e.lo;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int k, output int bc);
        k = k0; bc = 0;
        while (done !== 1'b1 && k < 100) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo, div_by_zero, illegal_op} !== '0) begin
            fails++;
            $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h dbz=%b ill=%b, expected all 0", busy, done, hi, lo, div_by_zero, illegal_op);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max;
        int k, bc; exp_t e, g;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 33));
        wait_done(0, k, bc);
        e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
        checks++;
        if (g !== e) begin fails++; $display("FAIL multu_max: got %p expected %p", g, e); end
        checks++;
        if (bc != 33 || busy !== 1'b0) begin fails++; $display("FAIL multu_busy: got %0d busy cycles (busy at done=%b) expected 33 (0)", bc, busy); end
    endtask

    task automatic test_mult_b2b;
        int k, bc; exp_t e, g;
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 33));
        wait_done(0, k, bc);
        e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
        checks++;
        if (g !== e) begin fails++; $display("FAIL mult_neg: got %p expected %p", g, e); end
        issue(2'b01, 32'd5, 32'd6, mk(32'd0, 32'd30, 1'b0, 1'b0, 33));
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got busy=%b expected 1", busy); end
        wait_done(0, k, bc);
        e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
        checks++;
        if (g !== e) begin fails++; $display("FAIL b2b_multu: got %p expected %p", g, e); end
    endtask

    task automatic test_ignore;
        int k, bc; exp_t e, g;
        issue(2'b01, 32'd3, 32'd4, mk(32'd0, 32'd12, 1'b0, 1'b0, 33));
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, k, bc);
        e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
        checks++;
        if (g !== e) begin fails++; $display("FAIL ignore_start: got %p expected %p", g, e); end
    endtask

    task automatic test_reset_mid;
        int n;
        issue(2'b01, 32'd1000, 32'd77, mk(32'd0, 32'd0, 1'b0, 1'b0, 0));
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo, div_by_zero, illegal_op} !== '0) begin
            fails++;
            $display("FAIL reset_async: got busy=%b done=%b hi=%h lo=%h dbz=%b ill=%b, expected all 0", busy, done, hi, lo, div_by_zero, illegal_op);
        end
        void'(sb.pop_back());
        last_hi = '0; last_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin fails++; $display("FAIL reset_no_done: got %0d done pulses expected 0", n); end
    endtask

    task automatic test_random;
        int k, bc; exp_t e, g;
        logic [1:0] o; logic [31:0] x, y;
        for (int i = 0; i < 8; i++) begin
`ifdef MULDIV_DIV_EN
            o = 2'($urandom_range(0, 3));
`else
            o = 2'($urandom_range(0, 1));
`endif
            x = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 300));
            y = (i == 5) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            issue(o, x, y, model(o, x, y));
            wait_done(0, k, bc);
            e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
            checks++;
            if (g !== e) begin fails++; $display("FAIL random%0d op=%0d a=%h b=%h: got %p expected %p", i, o, x, y, g, e); end
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div;
        int k, bc; exp_t e, g;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 33));
        wait_done(0, k, bc);
        e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
        checks++;
        if (g !== e) begin fails++; $display("FAIL div_neg: got %p expected %p", g, e); end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0, 32'h8000_0000, 1'b0, 1'b0, 33));
        wait_done(0, k, bc);
        e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
        checks++;
        if (g !== e) begin fails++; $display("FAIL div_min: got %p expected %p", g, e); end
    endtask

    task automatic test_div_zero;
        int k, bc; exp_t e, g;
        issue(2'b11, 32'd100, 32'd0, mk(32'd100, 32'hFFFF_FFFF, 1'b1, 1'b0, 1));
        wait_done(0, k, bc);
        e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
        checks++;
        if (g !== e) begin fails++; $display("FAIL div_zero: got %p expected %p", g, e); end
        issue(2'b01, 32'd2, 32'd3, mk(32'd0, 32'd6, 1'b0, 1'b0, 33));
        checks++;
        if (div_by_zero !== 1'b0) begin fails++; $display("FAIL dbz_clear: got %b expected 0", div_by_zero); end
        wait_done(0, k, bc);
        e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
        checks++;
        if (g !== e) begin fails++; $display("FAIL after_dbz: got %p expected %p", g, e); end
    endtask
`else
    task automatic test_illegal;
        int k, bc; exp_t e, g;
        issue(2'b11, 32'd10, 32'd3, mk(last_hi, last_lo, 1'b0, 1'b1, 1));
        wait_done(0, k, bc);
        e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
        checks++;
        if (g !== e) begin fails++; $display("FAIL illegal_divu: got %p expected %p", g, e); end
        issue(2'b01, 32'd7, 32'd8, mk(32'd0, 32'd56, 1'b0, 1'b0, 33));
        checks++;
        if (illegal_op !== 1'b0) begin fails++; $display("FAIL ill_clear: got %b expected 0", illegal_op); end
        wait_done(0, k, bc);
        e = sb.pop_front(); g = '{hi, lo, div_by_zero, illegal_op, 8'(k)};
        checks++;
        if (g !== e) begin fails++; $display("FAIL after_ill: got %p expected %p", g, e); end
    endtask
`endif

    initial begin
        test_reset();
        test_multu_max();
        test_mult_b2b();
        test_ignore();
        test_reset_mid();
        test_random();
`ifdef MULDIV_DIV_EN
        test_div();
        test_div_zero();
`else
        test_illegal();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
